// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32 control constants: opcodes, ALU select codes, sequencer states and error codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_WORD  = 3'b010;

    localparam logic [3:0] ALU_CC_ADD = 4'b0010;
    localparam logic [3:0] ALU_CC_SUB = 4'b0110;
    localparam logic [3:0] ALU_CC_XOR = 4'b1100;
    localparam logic [3:0] ALU_CC_OR  = 4'b0001;
    localparam logic [3:0] ALU_CC_AND = 4'b0000;
    localparam logic [3:0] ALU_CC_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        return (op == OP_I) || is_mem_op(op);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port: valid/ready request with address-source and direction.
interface multicycle_controller_if;

    logic mem_valid;
    logic mem_ready;
    logic iord;
    logic mem_read;
    logic mem_write;

    modport master (
        output mem_valid, iord, mem_read, mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, iord, mem_read, mem_write,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_controller_alu_cc_decoder.sv
// Combinational (opcode, funct3, funct7) -> ALU operation select, flagging unsupported encodings.
module alu_cc_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_cc,
    output logic       illegal
);

    always_comb begin
        alu_cc  = ALU_CC_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    // funct7 only distinguishes SUB for register-register ops
                    F3_ADD:  alu_cc = (opcode == OP_R && funct7 == F7_SUB) ? ALU_CC_SUB : ALU_CC_ADD;
                    F3_XOR:  alu_cc = ALU_CC_XOR;
                    F3_OR:   alu_cc = ALU_CC_OR;
                    F3_AND:  alu_cc = ALU_CC_AND;
                    F3_SLT:  alu_cc = ALU_CC_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW, OP_SW: illegal = (funct3 != F3_WORD);
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with memory wait timeout, sticky error code and retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [6:0]                 opcode,
    input  logic [6:0]                 funct7,
    input  logic [2:0]                 funct3,
    multicycle_controller_if.master    mem,
    output logic                       ir_write,
    output logic                       pc_write,
    output logic                       reg_write,
    output logic                       mem2reg,
    output logic                       alu_src,
    output logic [3:0]                 alu_cc,
    output logic [CNT_W-1:0]           instret,
    output logic [1:0]                 error
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    state_t            after_retire;
    err_t              err_q, err_d;
    logic [WAIT_W-1:0] wait_q;
    logic [3:0]        dec_cc;
    logic              dec_illegal;
    logic              retire;
    logic              timed_out;
    logic              in_access;

    alu_cc_decoder u_dec (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_cc  (dec_cc),
        .illegal (dec_illegal)
    );

    // Ready in the final allowed wait cycle still completes the access
    assign timed_out    = !mem.mem_ready && (wait_q == WAIT_LAST);
    assign after_retire = run ? S_FETCH : S_IDLE;
    assign in_access    = (state_q == S_FETCH) || (state_q == S_MEM);
    assign error        = err_q;

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        retire        = 1'b0;
        mem.mem_valid = 1'b0;
        mem.iord      = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem2reg       = 1'b0;
        alu_src       = 1'b0;
        alu_cc        = '0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem.mem_valid = 1'b1;
                mem.mem_read  = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src = uses_imm(opcode);
                alu_cc  = dec_cc;
                state_d = is_mem_op(opcode) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem.mem_valid = 1'b1;
                mem.iord      = 1'b1;
                mem.mem_read  = (opcode == OP_LW);
                mem.mem_write = (opcode == OP_SW);
                alu_src       = 1'b1;
                alu_cc        = ALU_CC_ADD;
                if (mem.mem_ready) begin
                    if (opcode == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = after_retire;
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = (opcode == OP_LW);
                alu_src   = uses_imm(opcode);
                alu_cc    = dec_cc;
                retire    = 1'b1;
                state_d   = after_retire;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            err_q   <= ERR_NONE;
            wait_q  <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (retire) instret <= instret + CNT_W'(1);
            if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
                wait_q <= '0;
            else if (in_access && !mem.mem_ready)
                wait_q <= wait_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction flows, ALU decode, reset abort,
// illegal opcode and memory timeout boundary.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        ir_write, pc_write, reg_write, mem2reg, alu_src;
    logic [3:0]  alu_cc;
    logic [31:0] instret;
    logic [1:0]  error;
    logic [12:0] ctl;

    int unsigned n_vec;
    int unsigned n_err;

    multicycle_controller_if mem_bus ();

    multicycle_controller #(
        .MEM_TIMEOUT (15),
        .CNT_W       (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .opcode    (opcode),
        .funct7    (funct7),
        .funct3    (funct3),
        .mem       (mem_bus),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .mem2reg   (mem2reg),
        .alu_src   (alu_src),
        .alu_cc    (alu_cc),
        .instret   (instret),
        .error     (error)
    );

    // {mem_valid, iord, ir_write, pc_write, reg_write, mem2reg, alu_src, mem_read, mem_write, alu_cc}
    assign ctl = {mem_bus.mem_valid, mem_bus.iord, ir_write, pc_write, reg_write, mem2reg,
                  alu_src, mem_bus.mem_read, mem_bus.mem_write, alu_cc};

    localparam logic [12:0] C_OFF     = 13'b0_0_0_0_0_0_0_0_0_0000;
    localparam logic [12:0] C_FETCH_W = 13'b1_0_0_0_0_0_0_1_0_0000;
    localparam logic [12:0] C_FETCH_R = 13'b1_0_1_1_0_0_0_1_0_0000;
    localparam logic [12:0] C_MEM_LW  = 13'b1_1_0_0_0_0_1_1_0_0010;
    localparam logic [12:0] C_MEM_SW  = 13'b1_1_0_0_0_0_1_0_1_0010;
    localparam logic [12:0] C_EXEC_IM = 13'b0_0_0_0_0_0_1_0_0_0010;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_ctl(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        run   = 1'b0;
        mem_bus.mem_ready = 1'b0;
        set_insn(7'b0110011, 3'b000, 7'b0000000);
        #3;
        chk_ctl("reset_ctl", ctl, C_OFF);
        chk("reset_instret", instret, 32'd0);
        chk("reset_error", 32'(error), 32'd0);

        // ADD with zero-wait memory
        tick();
        reset = 1'b1;
        run   = 1'b1;
        mem_bus.mem_ready = 1'b1;
        #1 chk_ctl("idle", ctl, C_OFF);
        tick(); chk_ctl("add_fetch", ctl, C_FETCH_R);
        tick(); chk_ctl("add_decode", ctl, C_OFF);
        tick(); chk_ctl("add_exec", ctl, 13'b0_0_0_0_0_0_0_0_0_0010);
        tick(); chk_ctl("add_wb", ctl, 13'b0_0_0_0_1_0_0_0_0_0010);
        chk("add_wb_instret", instret, 32'd0);
        tick(); chk_ctl("add_refetch", ctl, C_FETCH_R);
        chk("add_instret", instret, 32'd1);

        // ADDI with funct7=0100000 must stay ADD
        set_insn(7'b0010011, 3'b000, 7'b0100000);
        tick(); chk_ctl("addi_decode", ctl, C_OFF);
        tick(); chk_ctl("addi_exec", ctl, C_EXEC_IM);
        tick(); chk_ctl("addi_wb", ctl, 13'b0_0_0_0_1_0_1_0_0_0010);
        tick(); chk("addi_instret", instret, 32'd2);

        // R-type SUB
        set_insn(7'b0110011, 3'b000, 7'b0100000);
        tick();
        tick(); chk_ctl("sub_exec", ctl, 13'b0_0_0_0_0_0_0_0_0_0110);
        tick(); chk_ctl("sub_wb", ctl, 13'b0_0_0_0_1_0_0_0_0_0110);
        tick(); chk("sub_instret", instret, 32'd3);

        // ORI, then drop run: instruction completes and sequencer parks in IDLE
        set_insn(7'b0010011, 3'b110, 7'b0000000);
        tick();
        tick(); chk_ctl("ori_exec", ctl, 13'b0_0_0_0_0_0_1_0_0_0001);
        tick(); chk_ctl("ori_wb", ctl, 13'b0_0_0_0_1_0_1_0_0_0001);
        run = 1'b0;
        tick(); chk_ctl("ori_idle", ctl, C_OFF);
        chk("ori_instret", instret, 32'd4);
        tick(); chk_ctl("idle_hold", ctl, C_OFF);

        // LW with three wait cycles in MEM: 8 cycles FETCH..WB
        run = 1'b1;
        set_insn(7'b0000011, 3'b010, 7'b0000000);
        tick(); chk_ctl("lw_fetch", ctl, C_FETCH_R);
        tick(); chk_ctl("lw_decode", ctl, C_OFF);
        tick(); chk_ctl("lw_exec", ctl, C_EXEC_IM);
        mem_bus.mem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(); chk_ctl($sformatf("lw_mem_wait%0d", i), ctl, C_MEM_LW);
        end
        tick();
        mem_bus.mem_ready = 1'b1;
        #1 chk_ctl("lw_mem_done", ctl, C_MEM_LW);
        tick(); chk_ctl("lw_wb", ctl, 13'b0_0_0_0_1_1_1_0_0_0010);
        chk("lw_wb_instret", instret, 32'd4);
        tick(); chk_ctl("lw_refetch", ctl, C_FETCH_R);
        chk("lw_instret", instret, 32'd5);

        // SW, reset asserted mid-MEM
        set_insn(7'b0100011, 3'b010, 7'b0000000);
        tick();
        tick(); chk_ctl("sw_exec", ctl, C_EXEC_IM);
        mem_bus.mem_ready = 1'b0;
        tick(); chk_ctl("sw_mem", ctl, C_MEM_SW);
        tick(); chk_ctl("sw_mem_hold", ctl, C_MEM_SW);
        #3 reset = 1'b0;
        #1 chk_ctl("sw_abort_ctl", ctl, C_OFF);
        chk("sw_abort_instret", instret, 32'd0);
        chk("sw_abort_error", 32'(error), 32'd0);
        tick();
        reset = 1'b1;
        mem_bus.mem_ready = 1'b1;
        set_insn(7'b0110011, 3'b000, 7'b0000000);
        #1 chk_ctl("rst_idle", ctl, C_OFF);
        tick(); chk_ctl("rst_first_fetch", ctl, C_FETCH_R);
        chk("rst_instret", instret, 32'd0);
        tick();
        tick();
        tick();
        tick(); chk("rst_add_instret", instret, 32'd1);

        // Illegal opcode
        set_insn(7'b1111111, 3'b000, 7'b0000000);
        tick(); chk("ill_decode_error", 32'(error), 32'd0);
        tick(); chk_ctl("ill_error_ctl", ctl, C_OFF);
        chk("ill_error", 32'(error), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ill_hold_pcw%0d", i), 32'(pc_write), 32'd0);
            chk($sformatf("ill_hold_instret%0d", i), instret, 32'd1);
        end
        chk("ill_sticky", 32'(error), 32'd1);
        reset = 1'b0;
        #1 chk("ill_reset_error", 32'(error), 32'd0);

        // Fetch timeout after exactly 15 cycles without ready
        tick();
        reset = 1'b1;
        mem_bus.mem_ready = 1'b0;
        set_insn(7'b0110011, 3'b000, 7'b0000000);
        for (int i = 1; i <= 15; i++) begin
            tick(); chk_ctl($sformatf("to_fetch%0d", i), ctl, C_FETCH_W);
        end
        tick(); chk_ctl("to_error_ctl", ctl, C_OFF);
        chk("to_error", 32'(error), 32'd2);
        tick(); chk("to_sticky", 32'(error), 32'd2);

        // Ready arriving in cycle 15 completes the fetch
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick(); chk_ctl($sformatf("late_fetch%0d", i), ctl, C_FETCH_W);
        end
        tick();
        mem_bus.mem_ready = 1'b1;
        #1 chk_ctl("late_fetch15", ctl, C_FETCH_R);
        tick(); chk_ctl("late_decode", ctl, C_OFF);
        chk("late_error", 32'(error), 32'd0);
        tick(); chk_ctl("late_exec", ctl, 13'b0_0_0_0_0_0_0_0_0_0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
